// File: rtl/half_argmax.sv
// half_argmax: streaming argmax over LENGTH binary16 elements.
// One element per in_valid cycle; result registered one cycle after the last.
module half_argmax #(
  parameter int LENGTH = 10,
  parameter int IDX_W  = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      a,
  output logic             out_valid,
  output logic [IDX_W-1:0] index,
  output logic [15:0]      max_value
);

  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_cand;
  logic [CNT_W-1:0] r_cand_idx;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_index;
  logic [15:0]      r_max;

  logic             w_a_nan;
  logic             w_c_nan;
  logic [15:0]      w_a_key;
  logic [15:0]      w_c_key;
  logic             w_gt;
  logic             w_last;
  logic [15:0]      w_win;
  logic [CNT_W-1:0] w_win_idx;

  assign w_a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
  assign w_c_nan = (r_cand[14:10] == 5'h1f) && (r_cand[9:0] != 10'h0);

  // Monotonic key: -0 folds onto +0, negatives sort below positives.
  function automatic logic [15:0] okey(input logic [15:0] h);
    logic neg;
    neg = h[15] && (h[14:0] != 15'h0);
    return neg ? {1'b0, ~h[14:0]} : {1'b1, h[14:0]};
  endfunction

  assign w_a_key = okey(a);
  assign w_c_key = okey(r_cand);

  assign w_gt = !w_a_nan && (w_c_nan || (w_a_key > w_c_key));

  assign w_last    = (r_state == S_ACCUM) && (r_cnt == LAST);
  assign w_win     = w_gt ? a : r_cand;
  assign w_win_idx = w_gt ? r_cnt : r_cand_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_cand_idx  <= '0;
      r_out_valid <= 1'b0;
      r_index     <= '0;
      r_max       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (clear) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (in_valid) begin
        if (r_state == S_IDLE) begin
          r_cand     <= a;
          r_cand_idx <= '0;
          r_cnt      <= CNT_W'(1);
          r_state    <= S_ACCUM;
        end else if (w_last) begin
          r_index     <= IDX_W'(w_win_idx);
          r_max       <= w_win;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
          r_cnt       <= '0;
        end else begin
          if (w_gt) begin
            r_cand     <= a;
            r_cand_idx <= r_cnt;
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign index     = r_index;
  assign max_value = r_max;

endmodule

// File: doc/half_argmax.md
HALF_ARGMAX -- requirements
Module: half_argmax

Interface
REQ-001 Parameter LENGTH, default 10, SHALL be the number of half-precision elements per input vector (LENGTH >= 2).
REQ-002 Parameter IDX_W, default $clog2(LENGTH), SHALL be the width of the index output.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-005 Port clear, input, 1 bit, SHALL abort any partially received vector.
REQ-006 Port in_valid, input, 1 bit, SHALL qualify a: one element accepted per cycle when high.
REQ-007 Port a, input, 16 bits, SHALL be the IEEE-754 binary16 element, in index order 0..LENGTH-1. It is the serial stream of the upstream sigmoid stage.
REQ-008 Port out_valid, output, 1 bit, SHALL be a one-cycle pulse marking a new result.
REQ-009 Port index, output, IDX_W bits, SHALL be the position of the maximum element.
REQ-010 Port max_value, output, 16 bits, SHALL be the maximum element's raw encoding.

Function
REQ-011 The block SHALL have states IDLE (element count 0) and ACCUM (count 1..LENGTH-1).
- IDLE + in_valid: load candidate = a, candidate index = 0, count = 1, go to ACCUM.
- ACCUM + in_valid: compare a against the candidate and increment count.
REQ-012 On the element with count == LENGTH-1, the block SHALL:
- register the final winner into index/max_value, including that element in the comparison;
- return to IDLE;
- assert out_valid on the next cycle only (latency 1 cycle from the last accepted element).
REQ-013 index and max_value SHALL hold their last result until the next result is produced, and SHALL NOT change while a vector is in progress.
REQ-014 Back-to-back vectors SHALL be supported with no gap: an element of the next vector accepted in the same cycle out_valid is high is element 0 of that vector.
REQ-015 in_valid low SHALL stall the count without losing state; gaps of any length are allowed within a vector.
REQ-016 Comparison SHALL be binary16 ordering on sign-magnitude:
- positive > negative;
- for two positives, larger {exp,mant} is greater;
- for two negatives, smaller {exp,mant} is greater;
- +0 and -0 are equal;
- infinities are ordered normally.
REQ-017 A new element SHALL replace the candidate only when strictly greater; ties keep the earliest index.
REQ-018 A NaN (exp == 31, mant != 0) SHALL never replace a candidate.
REQ-019 A NaN candidate SHALL be replaced by the first non-NaN element that follows it.
REQ-020 If all elements are NaN, the result SHALL be index 0 with max_value equal to element 0.
REQ-021 clear SHALL return the block to IDLE with count 0 and no out_valid. clear with in_valid in the same cycle: clear wins and the element is discarded.
REQ-022 clear SHALL NOT modify index or max_value.
REQ-023 The comparison SHALL be purely combinational on the registered candidate and a, with no arithmetic on values (no rounding).

Reset
REQ-024 While rst is high, the block SHALL force:
- state IDLE and count 0;
- out_valid 0, index 0, max_value 16'h0000;
- internal candidate 0.
REQ-025 rst SHALL take priority over clear and in_valid.
REQ-026 A vector interrupted by rst SHALL be discarded, and the first in_valid after rst is deasserted SHALL be element 0.

Verification
REQ-027 LENGTH=4, stream 3800,3C00,3A00,3400 contiguous: one cycle after the 4th element, out_valid=1 for 1 cycle, index=1, max_value=3C00.
REQ-028 Stream BC00,C000,8000,0000: index=2, max_value=8000, showing the tie between -0 and +0 keeps the earliest.
REQ-029 Stream 7E00,3400,7C00,7E00: index=2, max_value=7C00. Stream 7E00 x4: index=0, max_value=7E00.
REQ-030 Two vectors back-to-back with no gap, the second being 3400,3400,3800,3400: out_valid pulses exactly twice, and the second result is index=2, max_value=3800. Random in_valid gaps give identical results.
REQ-031 After 2 elements, assert clear (with in_valid high) and then send a full vector: no spurious out_valid, the result reflects only the new vector, and outputs are unchanged until it completes.
REQ-032 Assert rst mid-vector: all outputs read 0 on the cycle after rst is sampled, and a following vector yields the correct result from element 0.
